uart_rx: RTL and testbench

- UART receiver; the input-side counterpart of the core's serial transmit path.
- Takes the raw serial line from the uart_sin input pad and synchronises it into clk.
- Decodes 8N1 frames, LSB first, with a fixed clocks-per-bit divisor and mid-bit sampling.
- Presents each received byte to the core through a one-entry valid/ready holding register, with framing-error and overrun flags.

---
 rtl/uart_rx.sv | 148 ++++++++++++++
 tb/tb_uart_rx.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// 8N1 UART receiver: two-flop input synchroniser, mid-bit sampling FSM and a
// one-entry valid/ready holding register with framing-error and overrun pulses.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// IDLE      | line idle, waiting for sin_s to go low
// START     | counting to mid start bit, rejecting glitches
// DATA      | sampling 8 data bits, LSB first, one every CLK_DIV cycles
// STOP      | sampling the stop bit; high delivers the byte, low is a framing error
// WAIT_HIGH | after a framing error, waiting for the line to return high
module uart_rx #(
    parameter int CLK_DIV = 434,
    parameter int CNT_W   = $clog2(CLK_DIV)
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       uart_sin,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       frame_err,
    output logic       overrun,
    output logic       busy
);

    localparam int HALF = CLK_DIV / 2;
    localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(HALF - 1);
    localparam logic [CNT_W-1:0] DIV_M1  = CNT_W'(CLK_DIV - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_HIGH
    } state_t;

    state_t           state, state_nxt;
    logic             s1, sin_s;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [2:0]       bit_idx, bit_idx_nxt;
    logic [7:0]       shift_reg, shift_nxt;
    logic [7:0]       rx_data_nxt;
    logic             rx_valid_nxt, frame_err_nxt, overrun_nxt;
    logic             deliver;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1        <= 1'b1;
            sin_s     <= 1'b1;
            state     <= IDLE;
            cnt       <= '0;
            bit_idx   <= '0;
            shift_reg <= '0;
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            s1        <= uart_sin;
            sin_s     <= s1;
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            bit_idx   <= bit_idx_nxt;
            shift_reg <= shift_nxt;
            rx_data   <= rx_data_nxt;
            rx_valid  <= rx_valid_nxt;
            frame_err <= frame_err_nxt;
            overrun   <= overrun_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        cnt_nxt       = cnt;
        bit_idx_nxt   = bit_idx;
        shift_nxt     = shift_reg;
        deliver       = 1'b0;
        frame_err_nxt = 1'b0;
        case (state)
            IDLE: begin
                cnt_nxt = '0;
                if (!sin_s) state_nxt = START;
            end
            START: begin
                if (cnt == HALF_M1) begin
                    cnt_nxt = '0;
                    if (!sin_s) begin
                        state_nxt   = DATA;
                        bit_idx_nxt = '0;
                    end else begin
                        state_nxt = IDLE;
                    end
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            DATA: begin
                if (cnt == DIV_M1) begin
                    cnt_nxt   = '0;
                    shift_nxt = {sin_s, shift_reg[7:1]};
                    if (bit_idx == 3'd7) state_nxt = STOP;
                    else                 bit_idx_nxt = bit_idx + 3'd1;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            STOP: begin
                if (cnt == DIV_M1) begin
                    cnt_nxt = '0;
                    if (sin_s) begin
                        deliver   = 1'b1;
                        state_nxt = IDLE;
                    end else begin
                        frame_err_nxt = 1'b1;
                        state_nxt     = WAIT_HIGH;
                    end
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            WAIT_HIGH: begin
                if (sin_s) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // A delivery may refill the register in the same cycle the core drains it.
    always_comb begin
        rx_data_nxt  = rx_data;
        rx_valid_nxt = rx_valid;
        overrun_nxt  = 1'b0;
        if (deliver) begin
            if (!rx_valid || rx_ready) begin
                rx_data_nxt  = shift_reg;
                rx_valid_nxt = 1'b1;
            end else begin
                overrun_nxt = 1'b1;
            end
        end else if (rx_valid && rx_ready) begin
            rx_valid_nxt = 1'b0;
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Directed-plus-random bench for uart_rx; expected event timing and holding
// register behaviour come from a frame-level model, not from the RTL structure.
module tb_uart_rx;

    localparam int CLK_DIV = 8;
    localparam int HALF    = CLK_DIV / 2;
    localparam int LAT     = 3 + HALF + 9 * CLK_DIV;  // negedge of pin drive -> observed event
    localparam int K_VALID = 0;
    localparam int K_FERR  = 1;
    localparam int K_OVR   = 2;

    typedef struct {
        int         cyc;
        int         kind;
        logic [7:0] data;
    } ev_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       uart_sin;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic       frame_err;
    logic       overrun;
    logic       busy;

    int  cyc = 0;
    int  checks = 0;
    int  errors = 0;
    int  valid_hi = 0;
    logic prev_valid = 1'b0;
    logic m_full = 1'b0;
    ev_t exp_q[$];
    ev_t act_q[$];

    uart_rx #(.CLK_DIV(CLK_DIV)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .uart_sin  (uart_sin),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .frame_err (frame_err),
        .overrun   (overrun),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        ev_t e;
        if (rx_valid && !prev_valid) begin
            e.cyc = cyc; e.kind = K_VALID; e.data = rx_data;
            act_q.push_back(e);
        end
        if (frame_err) begin
            e.cyc = cyc; e.kind = K_FERR; e.data = 8'h00;
            act_q.push_back(e);
        end
        if (overrun) begin
            e.cyc = cyc; e.kind = K_OVR; e.data = 8'h00;
            act_q.push_back(e);
        end
        if (rx_valid) valid_hi <= valid_hi + 1;
        prev_valid <= rx_valid;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    // Frame-level model: event time from pin fall, outcome from stop bit and holding state.
    task automatic send_frame(input logic [7:0] b, input logic stop_b);
        ev_t e;
        logic [9:0] bits;
        bits  = {stop_b, b, 1'b0};
        e.cyc = cyc + LAT;
        if (!stop_b) begin
            e.kind = K_FERR; e.data = 8'h00;
        end else if (m_full && !rx_ready) begin
            e.kind = K_OVR; e.data = 8'h00;
        end else begin
            e.kind = K_VALID; e.data = b;
            m_full = !rx_ready;
        end
        exp_q.push_back(e);
        for (int i = 0; i < 10; i++) begin
            uart_sin = bits[i];
            repeat (CLK_DIV) @(negedge clk);
        end
    endtask

    task automatic check_events(input string tag);
        checks++;
        assert (act_q.size() === exp_q.size()) else begin
            errors++;
            $error("FAIL %s event_count observed=%0d expected=%0d", tag, act_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < act_q.size(); i++) begin
            checks++;
            assert ({act_q[i].cyc, act_q[i].kind, act_q[i].data} ===
                    {exp_q[i].cyc, exp_q[i].kind, exp_q[i].data}) else begin
                errors++;
                $error("FAIL %s event%0d observed=cyc%0d/kind%0d/0x%02h expected=cyc%0d/kind%0d/0x%02h",
                       tag, i, act_q[i].cyc, act_q[i].kind, act_q[i].data,
                       exp_q[i].cyc, exp_q[i].kind, exp_q[i].data);
            end
        end
        act_q.delete();
        exp_q.delete();
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_rx_data"},   32'(rx_data),   32'h00);
        chk({tag, "_rx_valid"},  32'(rx_valid),  32'h0);
        chk({tag, "_frame_err"}, 32'(frame_err), 32'h0);
        chk({tag, "_overrun"},   32'(overrun),   32'h0);
        chk({tag, "_busy"},      32'(busy),      32'h0);
    endtask

    initial begin
        int v0, n, nfr;
        logic b_start, b_end;
        logic [7:0] rb;
        logic [7:0] tail;

        rst_n    = 1'b0;
        uart_sin = 1'b1;
        rx_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk_reset_outputs("reset");
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        // single frame 0x55
        v0 = valid_hi;
        send_frame(8'h55, 1'b1);
        repeat (4) @(negedge clk);
        check_events("frame_55");
        chk("frame_55_valid_cycles", 32'(valid_hi - v0), 32'd1);

        // back-to-back frames, zero idle gap
        v0 = valid_hi;
        send_frame(8'hA5, 1'b1);
        send_frame(8'h3C, 1'b1);
        repeat (4) @(negedge clk);
        check_events("b2b");
        chk("b2b_valid_cycles", 32'(valid_hi - v0), 32'd2);

        // random bytes with random idle gaps (including zero)
        v0  = valid_hi;
        nfr = 6;
        for (int i = 0; i < nfr; i++) begin
            rb = 8'($urandom);
            send_frame(rb, 1'b1);
            repeat ($urandom_range(0, 15)) @(negedge clk);
        end
        repeat (4) @(negedge clk);
        check_events("random");
        chk("random_valid_cycles", 32'(valid_hi - v0), 32'(nfr));

        // 2-cycle glitch: START entered then abandoned at the mid-bit sample
        n = cyc;
        uart_sin = 1'b0;
        repeat (2) @(negedge clk);
        uart_sin = 1'b1;
        b_start = 1'b0;
        b_end   = 1'b1;
        for (int k = 0; k < HALF + 8; k++) begin
            if (cyc == n + 3)        b_start = busy;
            if (cyc == n + HALF + 3) b_end   = busy;
            @(negedge clk);
        end
        chk("glitch_busy_start", 32'(b_start), 32'h1);
        chk("glitch_busy_end",   32'(b_end),   32'h0);
        check_events("glitch");

        // bad stop bit then break: one frame_err, busy until line high + 2
        send_frame(8'hFF, 1'b0);
        repeat (40) @(negedge clk);
        chk("break_busy_low", 32'(busy), 32'h1);
        uart_sin = 1'b1;
        repeat (2) @(negedge clk);
        chk("break_busy_hold", 32'(busy), 32'h1);
        @(negedge clk);
        chk("break_busy_release", 32'(busy), 32'h0);
        repeat (4) @(negedge clk);
        check_events("break");

        // overrun: holding register full when the second byte arrives
        rx_ready = 1'b0;
        send_frame(8'h11, 1'b1);
        send_frame(8'h22, 1'b1);
        repeat (4) @(negedge clk);
        check_events("overrun");
        chk("overrun_rx_data",  32'(rx_data),  32'h11);
        chk("overrun_rx_valid", 32'(rx_valid), 32'h1);
        rx_ready = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;
        m_full   = 1'b0;
        chk("accept_rx_valid", 32'(rx_valid), 32'h0);
        chk("accept_rx_data",  32'(rx_data),  32'h11);
        @(negedge clk);
        rx_ready = 1'b1;

        // one-cycle reset during bit 4 of 0x96, then a clean 0xC3
        tail = 8'h96;
        uart_sin = 1'b0;
        repeat (CLK_DIV) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            uart_sin = tail[i];
            repeat (CLK_DIV) @(negedge clk);
        end
        uart_sin = tail[4];
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk_reset_outputs("midreset");
        repeat (CLK_DIV - 4) @(negedge clk);
        for (int i = 5; i < 8; i++) begin
            uart_sin = tail[i];
            repeat (CLK_DIV) @(negedge clk);
        end
        uart_sin = 1'b1;
        repeat (16 * CLK_DIV) @(negedge clk);
        act_q.delete();
        exp_q.delete();
        m_full = 1'b0;
        send_frame(8'hC3, 1'b1);
        repeat (4) @(negedge clk);
        check_events("after_reset");
        chk("after_reset_rx_data", 32'(rx_data), 32'hC3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
